// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI voice controller, plus the
// elaboration-time phase-increment function used to fill the note ROM.
package midi_pkg;

    typedef enum logic [2:0] {S_STATUS, S_D1, S_D2, S_LOOK, S_LOAD} state_t;

    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [7:0] RT_MIN      = 8'hF8;

    // round(f_note * 2^24 / fs), f_note = 440 * 2^((note-69)/12).
    // Semitone ratio from a table, octave by exact power-of-two scaling.
    function automatic logic [23:0] note_inc(input int note, input int fs);
        int  d, k, oct;
        real r, f;
        d   = note - 69;
        k   = ((d % 12) + 12) % 12;
        oct = (d - k) / 12;
        case (k)
            0:       r = 1.0;
            1:       r = 1.0594630943592953;
            2:       r = 1.1224620483093730;
            3:       r = 1.1892071150027210;
            4:       r = 1.2599210498948732;
            5:       r = 1.3348398541700344;
            6:       r = 1.4142135623730951;
            7:       r = 1.4983070768766815;
            8:       r = 1.5874010519681994;
            9:       r = 1.6817928305074290;
            10:      r = 1.7817974362806785;
            11:      r = 1.8877486253633868;
            default: r = 1.0;
        endcase
        f = 440.0 * r;
        if (oct >= 0) begin
            for (int i = 0; i < oct; i++) f = f * 2.0;
        end else begin
            for (int i = 0; i < -oct; i++) f = f / 2.0;
        end
        return 24'($rtoi(f * 16777216.0 / $itor(fs) + 0.5));
    endfunction

endpackage

// File: rtl/midi_note_rom.sv
// 128 x 24 note-number to NCO phase-increment ROM, registered output
// (one cycle latency). Contents are fixed at elaboration from FS_HZ.
module midi_note_rom #(
    parameter int FS_HZ = 48000
) (
    input  logic        Clk,
    input  logic [6:0]  addr,
    output logic [23:0] data
);
    import midi_pkg::*;

    logic [23:0] tab [128];

    for (genvar i = 0; i < 128; i++) begin : g_tab
        assign tab[i] = note_inc(i, FS_HZ);
    end

    always_ff @(posedge Clk) begin
        data <= tab[addr];
    end

endmodule

// File: rtl/midi_voice_ctrl.sv
// MIDI byte parser and monophonic (last-note priority) voice controller
// feeding one NCO. Define MIDI_OMNI_EN to accept Note On/Off on all channels.
module midi_voice_ctrl #(
    parameter logic [3:0] MIDI_CH = 4'd0,
    parameter int         FS_HZ   = 48000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [23:0] F_in,
    output logic        loadF,
    output logic [15:0] A_in,
    output logic        loadA,
    output logic        key_on,
    output logic [6:0]  cur_note
);
    import midi_pkg::*;

`ifdef MIDI_OMNI_EN
    localparam bit OMNI = 1'b1;
`else
    localparam bit OMNI = 1'b0;
`endif

    state_t      state, state_nxt;
    logic        run_vld, run_on;
    logic [6:0]  note_r, vel_r;
    logic [23:0] rom_q;

    logic accept, is_rt, is_note_st;
    logic set_run, clr_run, ld_note, note_on, key_clr;

    assign accept     = byte_valid & byte_ready;
    assign is_rt      = (byte_in >= RT_MIN);
    assign is_note_st = ((byte_in[7:4] == ST_NOTE_OFF) || (byte_in[7:4] == ST_NOTE_ON))
                        && (OMNI || (byte_in[3:0] == MIDI_CH));
    assign loadF      = (state == S_LOAD);
    assign loadA      = (state == S_LOAD);

    midi_note_rom #(.FS_HZ(FS_HZ)) u_rom (
        .Clk  (Clk),
        .addr (note_r),
        .data (rom_q)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= S_STATUS;
            byte_ready <= 1'b0;
        end else begin
            state      <= state_nxt;
            byte_ready <= (state_nxt == S_STATUS) || (state_nxt == S_D1) || (state_nxt == S_D2);
        end
    end

    always_comb begin
        state_nxt = state;
        set_run   = 1'b0;
        clr_run   = 1'b0;
        ld_note   = 1'b0;
        note_on   = 1'b0;
        key_clr   = 1'b0;
        case (state)
            S_STATUS, S_D1, S_D2: begin
                // Realtime bytes are consumed without touching the parse state.
                if (accept && !is_rt) begin
                    if (byte_in[7]) begin
                        if (is_note_st) begin
                            set_run   = 1'b1;
                            state_nxt = S_D1;
                        end else begin
                            clr_run   = 1'b1;
                            state_nxt = S_STATUS;
                        end
                    end else if (state == S_D2) begin
                        if (run_on && (byte_in[6:0] != 7'd0)) begin
                            note_on   = 1'b1;
                            state_nxt = S_LOOK;
                        end else begin
                            key_clr   = (note_r == cur_note) && key_on;
                            state_nxt = S_D1;
                        end
                    end else if (state == S_D1 || run_vld) begin
                        ld_note   = 1'b1;
                        state_nxt = S_D2;
                    end
                end
            end
            S_LOOK:  state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_D1;
            default: state_nxt = S_STATUS;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            run_vld  <= 1'b0;
            run_on   <= 1'b0;
            note_r   <= 7'd0;
            vel_r    <= 7'd0;
            cur_note <= 7'd0;
            F_in     <= 24'd0;
            A_in     <= 16'd0;
            key_on   <= 1'b0;
        end else begin
            if (set_run) begin
                run_vld <= 1'b1;
                run_on  <= (byte_in[7:4] == ST_NOTE_ON);
            end else if (clr_run) begin
                run_vld <= 1'b0;
            end
            if (ld_note) note_r <= byte_in[6:0];
            if (note_on) begin
                vel_r    <= byte_in[6:0];
                cur_note <= note_r;
            end
            // ROM output for note_r has settled by S_LOOK; publish it on entry to S_LOAD.
            if (state == S_LOOK) begin
                F_in <= rom_q;
                A_in <= {1'b0, vel_r, 8'h00};
            end
            if (state == S_LOAD)  key_on <= 1'b1;
            else if (key_clr)     key_on <= 1'b0;
        end
    end

endmodule

// File: tb/tb_midi_voice_ctrl.sv
// Self-checking bench for midi_voice_ctrl: directed vector table, hand-built
// timing/reset sequences, and a random byte stream against an event model.
module tb_midi_voice_ctrl;

`ifdef MIDI_OMNI_EN
    localparam bit OMNI = 1'b1;
`else
    localparam bit OMNI = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [23:0] F_in;
    logic        loadF;
    logic [15:0] A_in;
    logic        loadA;
    logic        key_on;
    logic [6:0]  cur_note;

    midi_voice_ctrl dut (
        .Clk(Clk), .Reset(Reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .F_in(F_in), .loadF(loadF), .A_in(A_in),
        .loadA(loadA), .key_on(key_on), .cur_note(cur_note)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [39:0] load_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] ref_inc(input int n);
        real f;
        f = 440.0 * (2.0 ** ((n - 69) / 12.0));
        return 24'($rtoi(f * 16777216.0 / 48000.0 + 0.5));
    endfunction

    // Every NCO load seen by the voice is logged for later comparison.
    always @(negedge Clk) begin
        if (loadF || loadA) begin
            chk("loadA_eq_loadF", 32'(loadA), 32'(loadF));
            if (loadF) load_q.push_back({F_in, A_in});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge Clk);
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (!byte_ready) chk("byte_ready_timeout", 32'(byte_ready), 32'd1);
        @(posedge Clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Behavioural reference: byte-at-a-time message decoding that emits the
    // expected NCO load events and tracks the held note.
    bit          m_rs_vld, m_rs_on, m_key;
    int          m_phase;
    logic [6:0]  m_note, m_cur;
    logic [39:0] exp_q [$];

    task automatic model_reset();
        m_rs_vld = 0; m_rs_on = 0; m_key = 0; m_phase = 0;
        m_note = 7'd0; m_cur = 7'd0;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'hF8) return;
        if (b[7]) begin
            if ((b[7:4] == 4'h8 || b[7:4] == 4'h9) && (OMNI || b[3:0] == 4'h0)) begin
                m_rs_vld = 1; m_rs_on = (b[7:4] == 4'h9); m_phase = 1;
            end else begin
                m_rs_vld = 0; m_phase = 0;
            end
            return;
        end
        if (m_phase == 2) begin
            m_phase = 1;
            if (m_rs_on && b != 8'h00) begin
                exp_q.push_back({ref_inc(int'(m_note)), 1'b0, b[6:0], 8'h00});
                m_cur = m_note;
                m_key = 1;
            end else if (m_note == m_cur && m_key) begin
                m_key = 0;
            end
        end else if (m_phase == 1 || m_rs_vld) begin
            m_note  = b[6:0];
            m_phase = 2;
        end
    endtask

    typedef struct {
        int          nb;
        logic [31:0] bytes;
        bit          exp_load;
        logic [23:0] exp_f;
        logic [15:0] exp_a;
        bit          exp_key;
        logic [6:0]  exp_note;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [31:0] w;
        logic [7:0]  b;
        int          r;

        tbl[0]  = '{3, 32'h90456400, 1, 24'h0258BF, 16'h6400, 1, 7'h45};
        tbl[1]  = '{3, 32'h80400000, 0, 24'h0, 16'h0, 1, 7'h45};
        tbl[2]  = '{3, 32'h90450000, 0, 24'h0, 16'h0, 0, 7'h45};
        tbl[3]  = '{3, 32'h90456400, 1, 24'h0258BF, 16'h6400, 1, 7'h45};
        tbl[4]  = '{2, 32'h517F0000, 1, 24'h04B17E, 16'h7F00, 1, 7'h51};
        tbl[5]  = OMNI ? '{3, 32'h91456400, 1, 24'h0258BF, 16'h6400, 1, 7'h45}
                       : '{3, 32'h91456400, 0, 24'h0, 16'h0, 1, 7'h51};
        tbl[6]  = OMNI ? '{3, 32'h80510000, 0, 24'h0, 16'h0, 1, 7'h45}
                       : '{3, 32'h80510000, 0, 24'h0, 16'h0, 0, 7'h51};
        tbl[7]  = '{4, 32'h90F83C40, 1, ref_inc(60), 16'h4000, 1, 7'h3C};
        tbl[8]  = '{2, 32'h3C000000, 0, 24'h0, 16'h0, 0, 7'h3C};
        tbl[9]  = '{4, 32'hB0077F3C, 0, 24'h0, 16'h0, 0, 7'h3C};
        tbl[10] = '{2, 32'h3C500000, 0, 24'h0, 16'h0, 0, 7'h3C};

        // Reset values
        idle(2);
        chk("rst_byte_ready", 32'(byte_ready), 0);
        chk("rst_F_in", 32'(F_in), 0);
        chk("rst_loadF", 32'(loadF), 0);
        chk("rst_A_in", 32'(A_in), 0);
        chk("rst_loadA", 32'(loadA), 0);
        chk("rst_key_on", 32'(key_on), 0);
        chk("rst_cur_note", 32'(cur_note), 0);
        Reset = 1'b1;

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            w = tbl[i].bytes;
            for (int j = 0; j < tbl[i].nb; j++) send(w[31 - 8*j -: 8]);
            idle(4);
            chk($sformatf("vec%0d_loads", i), 32'(load_q.size()), 32'(tbl[i].exp_load));
            if (tbl[i].exp_load && load_q.size() > 0) begin
                chk($sformatf("vec%0d_F_in", i), 32'(load_q[0][39:16]), 32'(tbl[i].exp_f));
                chk($sformatf("vec%0d_A_in", i), 32'(load_q[0][15:0]), 32'(tbl[i].exp_a));
            end
            chk($sformatf("vec%0d_key_on", i), 32'(key_on), 32'(tbl[i].exp_key));
            chk($sformatf("vec%0d_cur_note", i), 32'(cur_note), 32'(tbl[i].exp_note));
            load_q.delete();
        end

        // Latency and back-pressure with byte_valid held through LOOK/LOAD
        send(8'h90); send(8'h45); send(8'h64);
        byte_in = 8'h80; byte_valid = 1'b1;
        @(negedge Clk);
        chk("lat_t1_byte_ready", 32'(byte_ready), 0);
        chk("lat_t1_loadF", 32'(loadF), 0);
        @(negedge Clk);
        chk("lat_t2_byte_ready", 32'(byte_ready), 0);
        chk("lat_t2_loadF", 32'(loadF), 1);
        chk("lat_t2_F_in", 32'(F_in), 32'h0258BF);
        chk("lat_t2_key_on", 32'(key_on), 0);
        @(negedge Clk);
        chk("lat_t3_byte_ready", 32'(byte_ready), 1);
        chk("lat_t3_key_on", 32'(key_on), 1);
        @(posedge Clk);
        #1 byte_valid = 1'b0;
        send(8'h45); send(8'h00);
        idle(3);
        chk("held_off_key_on", 32'(key_on), 0);
        chk("held_loads", 32'(load_q.size()), 1);
        load_q.delete();

        // Reset in the middle of a message
        send(8'h90); send(8'h45); send(8'h64);
        idle(4);
        send(8'h90); send(8'h3C);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("mid_rst_byte_ready", 32'(byte_ready), 0);
        chk("mid_rst_F_in", 32'(F_in), 0);
        chk("mid_rst_loadF", 32'(loadF), 0);
        chk("mid_rst_A_in", 32'(A_in), 0);
        chk("mid_rst_loadA", 32'(loadA), 0);
        chk("mid_rst_key_on", 32'(key_on), 0);
        chk("mid_rst_cur_note", 32'(cur_note), 0);
        @(negedge Clk);
        Reset = 1'b1;
        load_q.delete();
        send(8'h40);
        idle(4);
        chk("post_rst_stray_loads", 32'(load_q.size()), 0);
        send(8'h90); send(8'h3C); send(8'h40);
        idle(4);
        chk("post_rst_loads", 32'(load_q.size()), 1);
        if (load_q.size() > 0) begin
            chk("post_rst_F_in", 32'(load_q[0][39:16]), 32'(ref_inc(60)));
            chk("post_rst_A_in", 32'(load_q[0][15:0]), 32'h4000);
        end
        chk("post_rst_key_on", 32'(key_on), 1);
        load_q.delete();

        // Random stream against the model
        @(negedge Clk); Reset = 1'b0;
        @(negedge Clk); Reset = 1'b1;
        model_reset();
        load_q.delete();
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 12) begin
                case ($urandom_range(0, 9))
                    0: b = 8'h80;  1: b = 8'h90;  2: b = 8'h81;  3: b = 8'h91;
                    4: b = 8'h9F;  5: b = 8'hB0;  6: b = 8'hC0;  7: b = 8'hF0;
                    8: b = 8'h90;  default: b = 8'h80;
                endcase
            end else if (r < 17) begin
                b = 8'($urandom_range(8'hF8, 8'hFF));
            end else if (r < 30) begin
                b = 8'h00;
            end else if (r < 80) begin
                b = 8'(60 + $urandom_range(0, 3));
            end else begin
                b = 8'($urandom_range(0, 127));
            end
            model_byte(b);
            send(b);
            if (i % 50 == 49) begin
                idle(4);
                chk("rnd_key_on", 32'(key_on), 32'(m_key));
                chk("rnd_cur_note", 32'(cur_note), 32'(m_cur));
            end
        end
        idle(6);
        chk("rnd_load_count", 32'(load_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < load_q.size(); i++) begin
            chk($sformatf("rnd_load%0d_F", i), 32'(load_q[i][39:16]), 32'(exp_q[i][39:16]));
            chk($sformatf("rnd_load%0d_A", i), 32'(load_q[i][15:0]), 32'(exp_q[i][15:0]));
        end
        chk("rnd_final_key_on", 32'(key_on), 32'(m_key));
        chk("rnd_final_cur_note", 32'(cur_note), 32'(m_cur));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
